fsic_clock_rst_seq: RTL and testbench

//  Reset sequencer directly upstream of fsic_clock_div in the FSIC clock tree.

---
 rtl/fsic_clock_pkg.sv | 31 +++
 rtl/fsic_rst_sync.sv | 31 +++
 rtl/fsic_clock_rst_seq.sv | 179 +++++++++++++++++
 tb/tb_fsic_clock_rst_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsic_clock_pkg.sv
// Purpose: shared FSM encodings and default parameter values for the FSIC clock tree.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: ST_* state encodings (STATE_W bits), the state_t enum built on them,
// and the *_DEF default values used by fsic_clock_rst_seq and fsic_rst_sync.
package fsic_clock_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
    localparam logic [STATE_W-1:0] ST_SWRST = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_HOLD  = ST_HOLD,
        S_WAIT  = ST_WAIT,
        S_RUN   = ST_RUN,
        S_SWRST = ST_SWRST,
        S_ERR   = ST_ERR
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int HOLD_CYCLES_DEF = 8;
    localparam int LOCK_EDGES_DEF  = 4;
    localparam int TIMEOUT_DEF     = 64;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/fsic_rst_sync.sv
// Purpose: async-assert / sync-deassert reset synchronizer, reusable across FSIC domains.
// Latency: assertion immediate; deassertion visible on rst_s after SYNC_STAGES edges of in.
// Backpressure: none.
//
// Ports:
//   in      clock of the destination domain
//   resetb  raw asynchronous reset, active-low
//   rst_s   synchronized reset release, high once the chain has filled with ones
module fsic_rst_sync
    import fsic_clock_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic in,
    input  logic resetb,
    output logic rst_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge in or negedge resetb) begin
        if (!resetb) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fsic_clock_rst_seq.sv
// Purpose: reset sequencer ahead of fsic_clock_div: releases the divider, confirms div_clk toggles, then releases the core.
// Latency: div_resetb rises SYNC_STAGES+HOLD_CYCLES cycles after resetb; core release one cycle after the LOCK_EDGES-th div_clk rise.
// Backpressure: none; software reset is a 4-phase level handshake on sw_rst_req/sw_rst_ack.
//
// Ports:
//   in          source clock (same as the divider's input clock)
//   resetb      asynchronous active-low reset
//   sw_rst_req  software reset request (level)
//   div_clk     divider output, synchronous to in
//   div_resetb  divider reset, active-low
//   core_resetb divided-clock core reset, active-low
//   ready       high while in RUN
//   sw_rst_ack  software reset acknowledge
//   lock_err    sticky "div_clk never toggled" flag
//
// Build option: define FSIC_RST_TIMEOUT_EN to add the lock timeout (tcnt, ERR state,
// live lock_err). Without it WAIT waits indefinitely and lock_err is tied low.
module fsic_clock_rst_seq
    import fsic_clock_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int LOCK_EDGES  = LOCK_EDGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic in,
    input  logic resetb,
    input  logic sw_rst_req,
    input  logic div_clk,
    output logic div_resetb,
    output logic core_resetb,
    output logic ready,
    output logic sw_rst_ack,
    output logic lock_err
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    // Every count limit must be representable in the shared counter width.
    if (HOLD_CYCLES > CNT_MAX || LOCK_EDGES > CNT_MAX || TIMEOUT > CNT_MAX) begin : g_cnt_w_check
        $error("fsic_clock_rst_seq: CNT_W too narrow for HOLD_CYCLES/LOCK_EDGES/TIMEOUT");
    end

    logic             rst_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_clk_q;
    logic             div_edge;
    logic             div_resetb_d, core_resetb_d, ready_d, sw_rst_ack_d;
`ifdef FSIC_RST_TIMEOUT_EN
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             lock_err_d;
`endif

    fsic_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .in     (in),
        .resetb (resetb),
        .rst_s  (rst_s)
    );

    // div_clk is synchronous to in, so a single register is enough for edge detection.
    assign div_edge = div_clk & ~div_clk_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef FSIC_RST_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        lock_err_d = lock_err;
`endif

        // Until the synchronized release arrives the whole sequencer is frozen.
        if (rst_s) begin
            case (state_q)
                S_HOLD: begin
`ifdef FSIC_RST_TIMEOUT_EN
                    tcnt_d = '0;
`endif
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (div_edge && cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // A lock on the same cycle as the timeout wins.
                    if (div_edge && cnt_q == CNT_W'(LOCK_EDGES - 1)) begin
                        state_d = S_RUN;
                    end
`ifdef FSIC_RST_TIMEOUT_EN
                    else if (tcnt_q == CNT_W'(TIMEOUT - 1)) begin
                        lock_err_d = 1'b1;
                        state_d    = S_ERR;
                    end else if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
`endif
                end

                S_RUN: begin
                    if (sw_rst_req) begin
                        state_d = S_SWRST;
                    end
                end

                S_SWRST: begin
                    if (!sw_rst_req) begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end

`ifdef FSIC_RST_TIMEOUT_EN
                S_ERR: begin
                    if (sw_rst_req) begin
                        lock_err_d = 1'b0;
                        state_d    = S_SWRST;
                    end
                end
`endif

                default: begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end
            endcase
        end

        // Outputs are a decode of the next state, registered alongside it, so every
        // output changes on the same edge as the transition that implies it.
        div_resetb_d  = (state_d == S_WAIT) || (state_d == S_RUN) || (state_d == S_ERR);
        core_resetb_d = (state_d == S_RUN);
        ready_d       = (state_d == S_RUN);
        sw_rst_ack_d  = (state_d == S_SWRST);
    end

    always_ff @(posedge in or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            div_clk_q   <= 1'b0;
            div_resetb  <= 1'b0;
            core_resetb <= 1'b0;
            ready       <= 1'b0;
            sw_rst_ack  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_clk_q   <= div_clk;
            div_resetb  <= div_resetb_d;
            core_resetb <= core_resetb_d;
            ready       <= ready_d;
            sw_rst_ack  <= sw_rst_ack_d;
        end
    end

`ifdef FSIC_RST_TIMEOUT_EN
    always_ff @(posedge in or negedge resetb) begin
        if (!resetb) begin
            tcnt_q   <= '0;
            lock_err <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            lock_err <= lock_err_d;
        end
    end
`else
    assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsic_clock_rst_seq.sv
// Bench for fsic_clock_rst_seq with a behavioural /4 divider standing in for fsic_clock_div.
// Expected output vectors {div_resetb, core_resetb, ready, sw_rst_ack, lock_err} are queued
// before each clock and popped/compared at the following falling edge.
module tb_fsic_clock_rst_seq;

    // Default timing, in posedges of clk after the cycle that starts a sequence:
    // div_resetb rises at SYNC+HOLD = 10. The /4 divider then needs 2 cycles to its
    // first rise and 4 per rise after that, so the 4th rise follows 2+12 cycles and
    // the edge register sees it one cycle later: core release = div rise + 15.
    localparam int T_DIV      = 10;
    localparam int LOCK_DELAY = 15;
    localparam int T_CORE     = T_DIV + LOCK_DELAY;

    logic clk = 1'b0;
    logic resetb = 1'b1;
    logic sw_rst_req = 1'b0;
    logic force_low = 1'b0;
    logic div_clk;
    logic div_resetb, core_resetb, ready, sw_rst_ack, lock_err;
    logic [1:0] div_cnt;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge div_resetb) begin
        if (!div_resetb) div_cnt <= 2'd0;
        else             div_cnt <= div_cnt + 2'd1;
    end
    assign div_clk = div_cnt[1] & ~force_low;

    fsic_clock_rst_seq dut (
        .in          (clk),
        .resetb      (resetb),
        .sw_rst_req  (sw_rst_req),
        .div_clk     (div_clk),
        .div_resetb  (div_resetb),
        .core_resetb (core_resetb),
        .ready       (ready),
        .sw_rst_ack  (sw_rst_ack),
        .lock_err    (lock_err)
    );

    function automatic logic [4:0] obs();
        return {div_resetb, core_resetb, ready, sw_rst_ack, lock_err};
    endfunction

    function automatic logic [4:0] vec(bit d, bit c, bit a, bit l);
        return {d, c, c, a, l};
    endfunction

    // Stimulus only: assert resetb for 3 cycles, release at a falling edge.
    task automatic do_reset();
        sw_rst_req = 1'b0;
        resetb     = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        #1 resetb = 1'b0;
        #1;
        checks++;
        if (obs() !== 5'b0) begin
            errors++;
            $display("FAIL reset_immediate got=%b exp=%b", obs(), 5'b0);
        end
        for (int n = 1; n <= 5; n++) begin
            exp_q.push_back(5'b0);
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_hold n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
    endtask

    task automatic test_power_on();
        logic [4:0] e;
        resetb = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            exp_q.push_back(vec(n >= T_DIV, n >= T_CORE, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL power_on n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [4:0] e;
        do_reset();
        // Edges are counted at posedges 13 and 17; stop after the second one.
        for (int n = 1; n <= 18; n++) begin
            exp_q.push_back(vec(n >= T_DIV, 1'b0, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mid_wait_pre n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if (obs() !== 5'b0) begin
            errors++;
            $display("FAIL mid_wait_async got=%b exp=%b", obs(), 5'b0);
        end
        for (int n = 1; n <= 3; n++) begin
            exp_q.push_back(5'b0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mid_wait_held n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
        resetb = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            exp_q.push_back(vec(n >= T_DIV, n >= T_CORE, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mid_wait_rerun n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
    endtask

    // Entered in RUN. Request held over 3 posedges; ack drops on the 4th, HOLD then
    // runs 8 cycles without the synchronizer.
    task automatic test_sw_reset();
        logic [4:0] e;
        sw_rst_req = 1'b1;
        for (int m = 1; m <= 35; m++) begin
            exp_q.push_back(vec(m >= 12, m >= 12 + LOCK_DELAY, m <= 3, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL sw_reset m=%0d got=%b exp=%b", m, obs(), e);
            end
            if (m == 3) sw_rst_req = 1'b0;
        end
    endtask

    task automatic test_early_req();
        logic [4:0] e;
        logic d, c, a;
        do_reset();
        for (int n = 1; n <= 55; n++) begin
            if (n <= 30) begin
                d = (n >= T_DIV && n <= 25) || n >= 26 ? (n < 26) : 1'b0;
                c = (n == T_CORE);
                a = (n >= T_CORE + 1);
            end else begin
                d = (n >= 31 + 8);
                c = (n >= 31 + 8 + LOCK_DELAY);
                a = 1'b0;
            end
            if (n <= 30) d = (n >= T_DIV) && (n <= T_CORE);
            exp_q.push_back(vec(d, c, a, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL early_req n=%0d got=%b exp=%b", n, obs(), e);
            end
            if (n == 3)  sw_rst_req = 1'b1;
            if (n == 30) sw_rst_req = 1'b0;
        end
    endtask

`ifdef FSIC_RST_TIMEOUT_EN
    task automatic test_lock_timeout();
        logic [4:0] e;
        force_low = 1'b1;
        do_reset();
        for (int n = 1; n <= 115; n++) begin
            if (n <= 80)
                exp_q.push_back(vec(n >= T_DIV, 1'b0, 1'b0, n >= T_DIV + 64));
            else if (n <= 83)
                exp_q.push_back(vec(1'b0, 1'b0, 1'b1, 1'b0));
            else
                exp_q.push_back(vec(n >= 92, n >= 92 + LOCK_DELAY, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL lock_timeout n=%0d got=%b exp=%b", n, obs(), e);
            end
            if (n == 80) sw_rst_req = 1'b1;
            if (n == 83) begin
                sw_rst_req = 1'b0;
                force_low  = 1'b0;
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        logic [4:0] e;
        force_low = 1'b1;
        do_reset();
        for (int n = 1; n <= 1000; n++) begin
            exp_q.push_back(vec(n >= T_DIV, 1'b0, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL no_timeout n=%0d got=%b exp=%b", n, obs(), e);
            end
        end
        force_low = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_power_on();
        test_reset_mid_wait();
        test_sw_reset();
        test_early_req();
`ifdef FSIC_RST_TIMEOUT_EN
        test_lock_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
